// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Byte-lane field positions match the control unit's fetch.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    WR_LO,
    WR_HI,
    DONE,
    ERR
  } state_t;

  localparam logic MEM_CS_ON    = 1'b0;
  localparam logic MEM_CS_OFF   = 1'b1;
  localparam logic MEM_WR_WRITE = 1'b1;
  localparam logic MEM_WR_READ  = 1'b0;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 8;
  localparam int I_BIT  = 10;

endpackage

// File: rtl/program_loader_if.sv
// Instruction stream in, byte-wide memory write port out.
// slave = loader side, master = host/memory side.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_wr;
  logic              mem_cs;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output mem_addr, mem_data, mem_wr, mem_cs
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  mem_addr, mem_data, mem_wr, mem_cs
  );
endinterface

// File: rtl/program_loader.sv
// Streams 16-bit words into byte memory, low byte first.
// Raises cpu_release once the last word is written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  program_loader_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              cpu_release,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(MAX_WORDS);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] wc;
  logic [7:0]        hi_byte;
  logic              last;
  logic              wrap;
  logic              stop;

  // A further word would overflow the cap or the address space
  assign stop = ({1'b0, wc} == CAP) || (&ptr) || wrap;

  assign bus.in_ready = (state == WAIT) && !stop;
  assign busy         = !((state == IDLE) || (state == ERR));
  assign word_count   = wc;

  // Load sequencer with registered memory-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      wc           <= '0;
      hi_byte      <= '0;
      last         <= 1'b0;
      wrap         <= 1'b0;
      done         <= 1'b0;
      cpu_release  <= 1'b0;
      error        <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.mem_wr   <= MEM_WR_READ;
      bus.mem_cs   <= MEM_CS_OFF;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, ERR: begin
          if (start) begin
            ptr         <= base_addr;
            wc          <= '0;
            wrap        <= 1'b0;
            error       <= 1'b0;
            cpu_release <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (stop) begin
            error <= 1'b1;
            state <= ERR;
          end else if (bus.in_valid) begin
            hi_byte      <= bus.in_data[OPC_HI:DST_LO];
            last         <= bus.in_last;
            bus.mem_addr <= ptr;
            bus.mem_data <= bus.in_data[7:0];
            bus.mem_cs   <= MEM_CS_ON;
            bus.mem_wr   <= MEM_WR_WRITE;
            state        <= WR_LO;
          end
        end
        WR_LO: begin
          ptr          <= ptr + 1'b1;
          bus.mem_addr <= ptr + 1'b1;
          bus.mem_data <= hi_byte;
          state        <= WR_HI;
        end
        WR_HI: begin
          ptr        <= ptr + 1'b1;
          wc         <= wc + 1'b1;
          bus.mem_cs <= MEM_CS_OFF;
          bus.mem_wr <= MEM_WR_READ;
          if (&ptr) wrap <= 1'b1;
          if (last) begin
            done        <= 1'b1;
            cpu_release <= 1'b1;
            state       <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a byte-level
// expected-write queue and a memory image.
module tb_program_loader;

  localparam int MAXW = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic       busy, done, cpu_release, error;
  logic [7:0] word_count;

  program_loader_if #(.ADDR_W(8)) bus ();

  program_loader #(.ADDR_W(8), .MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .cpu_release (cpu_release),
    .error       (error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mem [256];
  logic [15:0] wds [8];

  function automatic void chk(input string n,
                              input logic [31:0] a,
                              input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  // Byte memory behind the write port
  always @(posedge clk)
    if (rst_n && bus.mem_cs == 1'b0 && bus.mem_wr)
      mem[bus.mem_addr] <= bus.mem_data;

  // Compare every write against the model's queue
  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (rst_n) begin
      if (done) done_cnt++;
      if (bus.mem_cs == 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: addr %0h data %0h expected none",
                   bus.mem_addr, bus.mem_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, bus.mem_addr}, {24'd0, e[15:8]});
          chk("wr_data", {24'd0, bus.mem_data}, {24'd0, e[7:0]});
          chk("wr_en", {31'd0, bus.mem_wr}, 32'd1);
        end
      end
    end
  end

  task automatic check_reset(input string t);
    chk({t, "_cs"}, {31'd0, bus.mem_cs}, 32'd1);
    chk({t, "_wr"}, {31'd0, bus.mem_wr}, 32'd0);
    chk({t, "_addr"}, {24'd0, bus.mem_addr}, 32'd0);
    chk({t, "_data"}, {24'd0, bus.mem_data}, 32'd0);
    chk({t, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({t, "_busy"}, {31'd0, busy}, 32'd0);
    chk({t, "_done"}, {31'd0, done}, 32'd0);
    chk({t, "_rel"}, {31'd0, cpu_release}, 32'd0);
    chk({t, "_err"}, {31'd0, error}, 32'd0);
    chk({t, "_wc"}, {24'd0, word_count}, 32'd0);
  endtask

  // Model: which words fit, and the byte writes they produce
  task automatic load(input logic [7:0] base, input int n,
                      input int gap, input bit poke);
    int p, nw, c, dc0;
    bit stop, acc;
    bit ok [8];
    p = int'(base);
    nw = 0;
    stop = 0;
    for (int i = 0; i < 8; i++) ok[i] = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= MAXW || p >= 255) begin
        stop = 1;
        break;
      end
      ok[i] = 1;
      exp_q.push_back({8'(p), wds[i][7:0]});
      exp_q.push_back({8'(p + 1), wds[i][15:8]});
      p += 2;
      nw++;
    end
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 8'h00;
    chk("start_rel_clr", {31'd0, cpu_release}, 32'd0);
    chk("start_err_clr", {31'd0, error}, 32'd0);
    chk("start_wc_clr", {24'd0, word_count}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == 0)
        repeat (gap) begin
          @(negedge clk);
          chk("gap_ready", {31'd0, bus.in_ready}, 32'd1);
          chk("gap_cs", {31'd0, bus.mem_cs}, 32'd1);
        end
      bus.in_valid = 1'b1;
      bus.in_data = wds[i];
      bus.in_last = (i == n - 1);
      c = 0;
      while (!bus.in_ready && !error && c < 20) begin
        @(negedge clk);
        c++;
      end
      acc = bus.in_ready;
      chk("accept", {31'd0, acc}, {31'd0, ok[i]});
      if (!acc) break;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data = 16'hDEAD;
      bus.in_last = 1'b0;
      if (poke && i == 0) begin
        start = 1'b1;
        base_addr = 8'h77;
      end
      @(negedge clk);
      chk("lo_cycle_cs", {31'd0, bus.mem_cs}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = 8'h00;
      @(negedge clk);
      chk("hi_cycle_cs", {31'd0, bus.mem_cs}, 32'd0);
      @(negedge clk);
      if (i == n - 1)
        chk("done_n3", {31'd0, done}, 32'd1);
      else
        chk("ready_n3", {31'd0, bus.in_ready}, {31'd0, ok[i+1]});
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_error", {31'd0, error}, {31'd0, stop});
    chk("end_release", {31'd0, cpu_release}, {31'd0, !stop});
    chk("end_wc", {24'd0, word_count}, 32'(nw));
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("done_pulses", 32'(done_cnt - dc0), stop ? 32'd0 : 32'd1);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0000;
    bus.in_last = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset("por");
    #20;
    @(posedge clk); #1 rst_n = 1'b1;

    // three-word program at 0x00
    wds[0] = 16'hB210;
    wds[1] = 16'hC5A0;
    wds[2] = 16'hF300;
    load(8'h00, 3, 0, 0);
    chk("m00", {24'd0, mem[0]}, 32'h10);
    chk("m01", {24'd0, mem[1]}, 32'hB2);
    chk("m02", {24'd0, mem[2]}, 32'hA0);
    chk("m03", {24'd0, mem[3]}, 32'hC5);
    chk("m04", {24'd0, mem[4]}, 32'h00);
    chk("m05", {24'd0, mem[5]}, 32'hF3);
    chk("wc3", {24'd0, word_count}, 32'd3);

    // in_valid withheld for 5 cycles
    wds[0] = 16'h1A2B;
    wds[1] = 16'h3C4D;
    load(8'h10, 2, 5, 0);
    chk("m10", {24'd0, mem[8'h10]}, 32'h2B);
    chk("m13", {24'd0, mem[8'h13]}, 32'h3C);

    // wrap at the top of memory
    wds[0] = 16'h1122;
    wds[1] = 16'h3344;
    wds[2] = 16'h5566;
    load(8'hFC, 3, 0, 0);
    chk("wrap_err", {31'd0, error}, 32'd1);
    chk("wrap_wc", {24'd0, word_count}, 32'd2);
    chk("mFC", {24'd0, mem[8'hFC]}, 32'h22);
    chk("mFF", {24'd0, mem[8'hFF]}, 32'h33);
    chk("m00_kept", {24'd0, mem[0]}, 32'h10);

    // base 0xFF refused outright
    wds[0] = 16'h7788;
    load(8'hFF, 1, 0, 0);
    chk("ff_wc", {24'd0, word_count}, 32'd0);

    // start while busy is ignored
    wds[0] = 16'h9ABC;
    wds[1] = 16'hDEF0;
    load(8'h80, 2, 0, 1);
    chk("m80", {24'd0, mem[8'h80]}, 32'hBC);
    chk("m83", {24'd0, mem[8'h83]}, 32'hDE);
    chk("m77_untouched", {24'd0, mem[8'h77]}, 32'h00);

    // reset during the high-byte write
    exp_q.push_back(16'h40CD);
    exp_q.push_back(16'h41AB);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 8'h40;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hABCD;
    bus.in_last = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cs", {31'd0, bus.mem_cs}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_q", 32'(exp_q.size()), 32'd0);
    chk("m40", {24'd0, mem[8'h40]}, 32'hCD);
    chk("m41", {24'd0, mem[8'h41]}, 32'h00);

    wds[0] = 16'h1234;
    load(8'h20, 1, 0, 0);
    chk("m20", {24'd0, mem[8'h20]}, 32'h34);
    chk("m21", {24'd0, mem[8'h21]}, 32'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
